add2_seg7_top: RTL and testbench
================================

Name: add2_seg7_top

Overview:
- Top-level display block: adds two 2-bit unsigned operands and shows the 3-bit sum (0..6) as one decimal digit on a 7-segment display.
- Sum and segment pattern are registered, so the output is glitch-free and cycle-aligned to the system clock.
- Sits at chip top, between switch/operand inputs and the segment pins.

Parameters:
- SEG_ACTIVE_LOW, 0, 0 = segment lit by 1 (common cathode); 1 = all output bits inverted (common anode).

Ports:
- clk  input  1  system clock, all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- a    input  2  operand A, unsigned 0..3
- b    input  2  operand B, unsigned 0..3
- out  output 7  segment drive, bit order {g,f,e,d,c,b,a} (out[0]=seg a, out[6]=seg g)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - With rst=1 at a rising edge, out becomes blank: 7'h00 when SEG_ACTIVE_LOW=0, 7'h7F when SEG_ACTIVE_LOW=1.
  - rst has priority over everything else.
- Arithmetic:
  - sum = a + b, computed in 3 bits, unsigned.
  - No overflow is possible; the maximum is 3+3=6.
- Segment encoding (active-high, gfedcba):
  - 0 = 0x3F
  - 1 = 0x06
  - 2 = 0x5B
  - 3 = 0x4F
  - 4 = 0x66
  - 5 = 0x6D
  - 6 = 0x7D
  - Code 7 is unreachable; the decoder maps it to 0x00 (blank).
- Polarity: when SEG_ACTIVE_LOW=1, out is the bitwise inverse of the pattern above.
- Latency:
  - a and b are sampled at rising edge N; out shows the matching digit after edge N (1-cycle latency).
  - No combinational path from a/b to out.
- Inputs change at most once per cycle. Each sampled pair produces exactly one registered output, with no intermediate values.
- Reset mid-operation: out blanks on the first edge where rst=1. The first edge after rst deasserts displays the sum of the a/b sampled at that edge.
- a/b containing X/Z is not supported; behaviour is undefined.

Decomposition:
- Shared package add2_seg7_pkg:
  - SEG_* localparams for the seven digit codes and SEG_BLANK.
  - Width constants: OPW=2, SUMW=3, SEGW=7.
- One sub-module, seg7_decoder:
  - Purely combinational.
  - Input: 3- or 4-bit value. Output: 7-bit active-high pattern.
  - Unused codes output blank.
- Top contains: the adder, the decoder instance, polarity inversion, and the output register with synchronous reset.

Test Plan:
- Hold rst=1 for 2 edges with a=3, b=3 -> out=0x00 (and 0x7F with SEG_ACTIVE_LOW=1); release rst -> next edge out=0x7D.
- a=0, b=0 -> out=0x3F; then a=1, b=0 -> 0x06; a=1, b=1 -> 0x5B. Each result appears exactly one edge after the inputs are applied.
- Sweep all 16 (a,b) pairs -> out matches the encoding of a+b; in particular a=2, b=1 -> 0x4F; a=2, b=2 -> 0x66; a=3, b=2 -> 0x6D.
- Change a and b between edges (0->1->2->3 on a, b toggling 0/1) -> out changes only at rising edges, never shows a value other than the last sampled sum.
- Assert rst for one cycle while a=3, b=1 -> out goes 0x66, then 0x00, then back to 0x66 on the following edge.
- SEG_ACTIVE_LOW=1, a=1, b=0 -> out=0x79 (inverse of 0x06).

Source files
------------

// File: rtl/add2_seg7_pkg.sv
// Shared widths and 7-segment digit codes (active-high, bit order gfedcba).
package add2_seg7_pkg;

    localparam int OPW  = 2;
    localparam int SUMW = 3;
    localparam int SEGW = 7;

    localparam logic [SEGW-1:0] SEG_0     = 7'h3F;
    localparam logic [SEGW-1:0] SEG_1     = 7'h06;
    localparam logic [SEGW-1:0] SEG_2     = 7'h5B;
    localparam logic [SEGW-1:0] SEG_3     = 7'h4F;
    localparam logic [SEGW-1:0] SEG_4     = 7'h66;
    localparam logic [SEGW-1:0] SEG_5     = 7'h6D;
    localparam logic [SEGW-1:0] SEG_6     = 7'h7D;
    localparam logic [SEGW-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational digit decoder: 3-bit value to active-high gfedcba pattern.
module seg7_decoder
    import add2_seg7_pkg::*;
(
    input  logic [SUMW-1:0] val,
    output logic [SEGW-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (val)
            3'd0:    seg = SEG_0;
            3'd1:    seg = SEG_1;
            3'd2:    seg = SEG_2;
            3'd3:    seg = SEG_3;
            3'd4:    seg = SEG_4;
            3'd5:    seg = SEG_5;
            3'd6:    seg = SEG_6;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/add2_seg7_top.sv
// Adds two 2-bit operands and drives the registered sum digit on a 7-seg display.
module add2_seg7_top
    import add2_seg7_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  a,
    input  logic [OPW-1:0]  b,
    output logic [SEGW-1:0] out
);

    localparam logic [SEGW-1:0] POL_MASK = SEG_ACTIVE_LOW ? '1 : '0;

    logic [SUMW-1:0] sum;
    logic [SEGW-1:0] seg;

    assign sum = {1'b0, a} + {1'b0, b};

    seg7_decoder u_dec (
        .val (sum),
        .seg (seg)
    );

    // Blank is inverted too, so common-anode parts go fully dark in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= SEG_BLANK ^ POL_MASK;
        end else begin
            out <= seg ^ POL_MASK;
        end
    end

endmodule

// File: tb/tb_add2_seg7_top.sv
// Directed bench for add2_seg7_top, both segment polarities side by side.
module tb_add2_seg7_top;

    logic       clk;
    logic       rst;
    logic [1:0] a;
    logic [1:0] b;
    logic [6:0] out_h;
    logic [6:0] out_l;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [0:6] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                                  7'h66, 7'h6D, 7'h7D};

    add2_seg7_top #(.SEG_ACTIVE_LOW(1'b0)) u_dut_h (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .out (out_h)
    );

    add2_seg7_top #(.SEG_ACTIVE_LOW(1'b1)) u_dut_l (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .out (out_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] got,
                         input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] prev;
        int s;

        rst = 1'b1;
        a   = 2'd3;
        b   = 2'd3;
        tick();
        tick();
        check("rst_h", out_h, 7'h00);
        check("rst_l", out_l, 7'h7F);

        rst = 1'b0;
        tick();
        check("rel_h", out_h, 7'h7D);
        check("rel_l", out_l, 7'h02);

        a = 2'd0;
        b = 2'd0;
        #2;
        check("lat_hold", out_h, 7'h7D);
        tick();
        check("a0b0", out_h, 7'h3F);
        a = 2'd1;
        b = 2'd0;
        #2;
        check("lat_hold2", out_h, 7'h3F);
        tick();
        check("a1b0", out_h, 7'h06);
        check("a1b0_l", out_l, 7'h79);
        a = 2'd1;
        b = 2'd1;
        tick();
        check("a1b1", out_h, 7'h5B);

        for (int i = 0; i < 16; i++) begin
            a = i[3:2];
            b = i[1:0];
            s = i / 4 + i % 4;
            tick();
            check($sformatf("sweep_a%0d_b%0d", i / 4, i % 4),
                  out_h, seg_tab[s]);
            check($sformatf("sweep_l_a%0d_b%0d", i / 4, i % 4),
                  out_l, ~seg_tab[s]);
        end

        for (int i = 0; i < 4; i++) begin
            prev = out_h;
            a = 2'd3 - i[1:0];
            b = 2'd1;
            #2;
            check($sformatf("mid_hold%0d", i), out_h, prev);
            a = i[1:0];
            b = i[0] ? 2'd1 : 2'd0;
            #2;
            check($sformatf("mid_hold%0d_b", i), out_h, prev);
            tick();
            check($sformatf("toggle%0d", i), out_h, seg_tab[i + (i % 2)]);
        end

        a = 2'd3;
        b = 2'd1;
        tick();
        check("pre_rst", out_h, 7'h66);
        rst = 1'b1;
        tick();
        check("mid_rst_h", out_h, 7'h00);
        check("mid_rst_l", out_l, 7'h7F);
        rst = 1'b0;
        tick();
        check("post_rst", out_h, 7'h66);
        check("post_rst_l", out_l, 7'h19);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
